// File: rtl/shifter_pipe.sv
// shifter_pipe: log-depth pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR/PASS) with valid/ready flow control
module shifter_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);
  localparam logic [2:0] SLL = 3'd0;
  localparam logic [2:0] SRL = 3'd1;
  localparam logic [2:0] SRA = 3'd2;
  localparam logic [2:0] ROL = 3'd3;
  localparam logic [2:0] ROR = 3'd4;

  logic             r_vld  [SHW];
  logic [WIDTH-1:0] r_data [SHW];
  logic [2:0]       r_mode [SHW-1];
  logic [SHW-1:0]   r_amt  [SHW-1];
  logic             r_fill [SHW-1];
  logic [SHW-1:0]   w_ld;

  // a stage may load if it or any stage downstream of it is empty, or the consumer takes the result
  always_comb begin
    logic c;
    w_ld = '0;
    c    = out_ready;
    for (int i = SHW - 1; i >= 0; i--) begin
      c       = c || !r_vld[i];
      w_ld[i] = c;
    end
  end

  assign in_ready  = w_ld[0];
  assign out_valid = r_vld[SHW-1];
  assign out_data  = r_data[SHW-1];
  assign out_zero  = ~|r_data[SHW-1];

  genvar k;
  for (k = 0; k < SHW; k++) begin : g_st
    localparam int S = 1 << k;
    logic             w_vld;
    logic             w_f;
    logic             w_en;
    logic [2:0]       w_m;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_sh;
    if (k == 0) begin : g_src
      assign w_vld = in_valid;
      assign w_d   = in_data;
      assign w_m   = in_mode;
      assign w_f   = in_data[WIDTH-1];
      assign w_en  = in_shamt[0];
    end else begin : g_src
      assign w_vld = r_vld[k-1];
      assign w_d   = r_data[k-1];
      assign w_m   = r_mode[k-1];
      assign w_f   = r_fill[k-1];
      assign w_en  = r_amt[k-1][k];
    end
    assign w_sh = !w_en      ? w_d :
                  w_m == SLL ? w_d << S :
                  w_m == SRL ? w_d >> S :
                  w_m == SRA ? {{S{w_f}}, w_d[WIDTH-1:S]} :
                  w_m == ROL ? {w_d[WIDTH-1-S:0], w_d[WIDTH-1:WIDTH-S]} :
                  w_m == ROR ? {w_d[S-1:0], w_d[WIDTH-1:S]} : w_d;
    // stage payload: shifted data and valid, held while the stage is stalled
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld[k]  <= 1'b0;
        r_data[k] <= '0;
      end else if (w_ld[k]) begin
        r_vld[k]  <= w_vld;
        r_data[k] <= w_sh;
      end
    end
    if (k < SHW - 1) begin : g_ctl
      logic [SHW-1:0] w_a;
      if (k == 0) begin : g_a
        assign w_a = in_shamt;
      end else begin : g_a
        assign w_a = r_amt[k-1];
      end
      // control that later stages still need: mode, amount, original sign bit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mode[k] <= '0;
          r_amt[k]  <= '0;
          r_fill[k] <= 1'b0;
        end else if (w_ld[k]) begin
          r_mode[k] <= w_m;
          r_amt[k]  <= w_a;
          r_fill[k] <= w_f;
        end
      end
    end
  end
endmodule

// File: doc/shifter_pipe.md
SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be a power of two, 8 to 64 inclusive.
REQ-002 Parameter SHW, default log2(WIDTH) (5), shift-amount width and pipeline depth; SHALL equal log2(WIDTH).
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port in_valid, input, 1, input operand valid.
REQ-006 Port in_ready, output, 1, block accepts the operand this cycle.
REQ-007 Port in_data, input, WIDTH, operand.
REQ-008 Port in_shamt, input, SHW, shift amount, 0 to WIDTH-1.
REQ-009 Port in_mode, input, 3, operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 PASS.
REQ-010 Port out_valid, output, 1, result valid.
REQ-011 Port out_ready, input, 1, consumer accepts result.
REQ-012 Port out_data, output, WIDTH, shifted result.
REQ-013 Port out_zero, output, 1, high when out_data is all zeros.

Function
REQ-014 Transfer in or out SHALL occur only on a cycle where the respective valid and ready are both high at the rising clk edge.
REQ-015 SLL SHALL shift left by in_shamt and fill vacated LSBs with 0.
REQ-016 SRL SHALL shift right by in_shamt and fill vacated MSBs with 0.
REQ-017 SRA SHALL shift right by in_shamt and fill vacated MSBs with in_data[WIDTH-1].
REQ-018 ROL/ROR SHALL rotate left/right by in_shamt with no bits lost.
REQ-019 PASS modes and any shamt of 0 SHALL return in_data unchanged.
REQ-020 Datapath SHALL be SHW registered stages; stage k conditionally applies a shift of 2^k using bit k of the amount; mode, amount and fill bit travel with the data.
REQ-021 Latency from input transfer to out_valid SHALL be exactly SHW cycles with out_ready held high.
REQ-022 Throughput SHALL be one operation per cycle when out_ready is continuously high.
REQ-023 Stage k SHALL load when its valid is 0 or stage k+1 loads that cycle; the last stage loads when its valid is 0 or out_ready is 1.
REQ-024 in_ready SHALL equal the stage-0 load condition, a combinational function of the valids and out_ready only, independent of in_valid.
REQ-025 A stage that does not load SHALL hold its data, mode, amount and valid unchanged.
REQ-026 A stage whose upstream has no valid item while it loads SHALL clear its valid.
REQ-027 With out_ready low, the pipeline SHALL absorb up to SHW operations, then deassert in_ready; no operation is lost, duplicated or reordered.
REQ-028 out_data and out_zero SHALL be driven from the last stage registers and stay stable while out_valid=1 and out_ready=0.
REQ-029 out_zero SHALL be computed from the last-stage data, combinationally or registered, and SHALL be valid whenever out_valid=1.
REQ-030 Operands SHALL be treated as unsigned bit vectors except for the SRA fill bit; no sign or overflow flag is produced.

Reset
REQ-031 rst_n low SHALL asynchronously clear all stage valids, forcing out_valid=0 and out_data=0, out_zero=1; in_ready SHALL read 1 after reset release.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight operations; no result from before reset appears afterwards.
REQ-033 Data registers SHALL reset to 0; the first valid result after reset depends only on post-reset inputs.

Verification
REQ-034 SLL 0x0000_0001 by 31, out_ready=1 -> out_data 0x8000_0000, out_valid exactly 5 cycles after the transfer.
REQ-035 SRA 0x8000_0000 by 4 -> 0xF800_0000; SRL of the same operand -> 0x0800_0000.
REQ-036 ROR 0x0000_0001 by 1 -> 0x8000_0000; ROL 0x8000_0001 by 4 -> 0x0000_0018; mode 111 of 0x1234_5678 -> 0x1234_5678.
REQ-037 SRL 0x0000_000F by 4 -> out_data 0, out_zero 1.
REQ-038 Six back-to-back inputs with out_ready=0 -> five accepted, in_ready low on the sixth; release out_ready -> five results in order with correct values, then the sixth is accepted.
REQ-039 rst_n pulsed low with three operations in flight -> out_valid 0 immediately; no stale result appears after release; a new operation completes in 5 cycles.
